// File: rtl/fdiv_pipe.sv
// ---------------------------------------------------------------------------
// fdiv_pipe -- pipelined IEEE-754 single-precision divider, y = x1 / x2,
// computed as x1 * finv(x2) with truncation.
//
// Ports (fdiv_pipe):
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, highest priority
//   in_valid   operand pair valid
//   in_ready   an operand pair can be accepted this cycle
//   x1, x2     dividend / divisor (IEEE-754 single)
//   out_valid  y holds a valid quotient (FIFO head)
//   out_ready  consumer takes y this cycle
//   y          quotient (0 while the FIFO is empty)
//
// Timing: a pair accepted at edge T is written into the output FIFO at edge
// T+2, so out_valid can rise in the cycle after edge T+2. The pipeline has
// no enable; a credit counter caps in-flight + buffered results at DEPTH so
// the FIFO can never overflow.
//
// Also contains finv, the one-cycle reciprocal unit feeding the multiplier.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// finv -- registered reciprocal, 1/x2 truncated to single precision.
//
// Ports:
//   clk   clock
//   x_i   operand, sampled every rising edge (no enable)
//   y_o   reciprocal of the operand sampled at the previous edge
//
// 1/(1.m * 2^(e-127)): for m == 0 the result is exactly 2^(127-e), i.e.
// biased exponent 254-e. For m != 0, 1/1.m lies in (0.5, 1), so the exponent
// drops by one (253-e) and the 24-bit significand is floor(2^47 / 1.m).
// Exponent 0 gives signed infinity; results below the normal range give
// signed zero.
// ---------------------------------------------------------------------------
module finv (
  input  logic        clk,
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  logic [31:0] x_q;
  logic [9:0]  exp_r;
  logic [22:0] mant_r;

  // NOTE: pure datapath registers carry no reset; a downstream valid bit
  // decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    x_q <= x_i;
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    mant_r = '0;
    exp_r  = 10'd254 - {2'b00, x_q[30:23]};
    if (x_q[22:0] != '0) begin
      exp_r  = 10'd253 - {2'b00, x_q[30:23]};
      // Quotient lies strictly between 2^23 and 2^24; keep the fraction bits.
      mant_r = 23'(48'h8000_0000_0000 / {24'h00_0000, 1'b1, x_q[22:0]});
    end

    if (x_q[30:23] == 8'h00) begin
      y_o = {x_q[31], 8'hFF, 23'h00_0000};
    end else if ($signed(exp_r) <= 10'sd0) begin
      y_o = {x_q[31], 31'h0000_0000};
    end else begin
      y_o = {x_q[31], exp_r[7:0], mant_r};
    end
  end

endmodule

module fdiv_pipe #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;                       // holds 0..DEPTH
  localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // -------------------------------------------------------------------------
  // Handshake and credits
  // -------------------------------------------------------------------------
  logic          accept;
  logic          wr_en;
  logic          pop;
  logic [CW:0]   credits_used;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic [31:0]       recip;
  // stage 1 (edge T)
  logic              v1_q;
  logic              s1_q;
  logic [7:0]        e1_q;
  logic [22:0]       m1_q;
  logic              x2z1_q;
  // stage 2 (edge T+1)
  logic [47:0]       prod_d;
  logic [9:0]        esum_d;
  logic              v2_q;
  logic [47:0]       prod_q;
  logic [9:0]        esum_q;
  logic              sign2_q;
  logic              x1z2_q;
  logic              x2z2_q;
  // stage 3 (combinational, written at edge T+2)
  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  logic [31:0]       result;

  logic [31:0]       mem_q [DEPTH];

  // in_ready looks only at held state and rst, never at in_valid, so the
  // issue logic can use it without a combinational loop.
  always_comb begin
    credits_used = {1'b0, inflight_q} + {1'b0, count_q};
    in_ready     = ~rst & (credits_used < DEPTH_C);
  end

  assign accept    = in_valid & in_ready;
  assign wr_en     = v2_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Stage 1: x2 goes to finv; x1 fields and the x2 zero-exponent flag wait
  // here for the reciprocal.
  // -------------------------------------------------------------------------
  finv u_finv (
    .clk (clk),
    .x_i (x2),
    .y_o (recip)
  );

  // NOTE: sequential state is assigned with non-blocking assignments only,
  // so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    s1_q   <= x1[31];
    e1_q   <= x1[30:23];
    m1_q   <= x1[22:0];
    x2z1_q <= (x2[30:23] == 8'h00);
  end

  // -------------------------------------------------------------------------
  // Stage 2: significand product and exponent sum. The reciprocal's sign bit
  // is the registered sign of x2.
  // -------------------------------------------------------------------------
  always_comb begin
    prod_d = {1'b1, m1_q} * {1'b1, recip[22:0]};
    esum_d = {2'b00, e1_q} + {2'b00, recip[30:23]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk) begin
    prod_q  <= prod_d;
    esum_q  <= esum_d;
    sign2_q <= s1_q ^ recip[31];
    x1z2_q  <= (e1_q == 8'h00);
    x2z2_q  <= x2z1_q;
  end

  // -------------------------------------------------------------------------
  // Stage 3: normalize (product is in [1,4)), truncate, apply specials.
  // e1+er is at most 510, so a 10-bit signed exponent cannot wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    if (prod_q[47]) begin
      exp_n = $signed(esum_q - 10'd126);
    end else begin
      exp_n = $signed(esum_q - 10'd127);
    end
    mant_n = 23'(prod_q >> (prod_q[47] ? 6'd24 : 6'd23));

    if (x2z2_q) begin
      result = {sign2_q, 8'hFF, 23'h00_0000};
    end else if (x1z2_q) begin
      result = {sign2_q, 31'h0000_0000};
    end else if (exp_n <= 10'sd0) begin
      result = {sign2_q, 31'h0000_0000};
    end else if (exp_n >= 10'sd255) begin
      result = {sign2_q, 8'hFF, 23'h00_0000};
    end else begin
      result = {sign2_q, exp_n[7:0], mant_n};
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO and credit counter. Credits guarantee a free slot for every
  // write, so wr_en needs no full check.
  // -------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !wr_en) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (wr_en && !accept) begin
      inflight_d = inflight_q - CNT_ONE;
    end

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !wr_en) begin
      count_d = count_q - CNT_ONE;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and
  // pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  // Head is held until popped; forced to zero while the FIFO is empty.
  assign y = out_valid ? mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: doc/fdiv_pipe.md
Name: fdiv_pipe

Overview:
- Pipelined single-precision divider, y = x1 / x2, computed as x1 × finv(x2).
- Sits directly downstream of the finv reciprocal unit: instantiates finv, consumes its 32-bit reciprocal and multiplies it by the delay-matched dividend.
- Adds valid/ready handshakes and an output FIFO so the FPU issue logic can stall without losing in-flight results, since finv has no enable.

Parameters:
- DEPTH, 4, output FIFO entries and also maximum results outstanding (in-flight + buffered); power of two, ≥ 4.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair this cycle
- x1  input  32  dividend (IEEE-754 single)
- x2  input  32  divisor (IEEE-754 single)
- out_valid  output  1  y holds a valid quotient (FIFO head)
- out_ready  input  1  consumer takes y this cycle
- y  output  32  quotient

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst has priority over all other inputs.
- Reset:
  - in_ready=0 while rst=1, then 1 from the first cycle after rst falls.
  - out_valid=0, y=0, FIFO empty, credit counter=0, all pipeline valid bits cleared.
  - Operations in flight when rst asserts are discarded; no result from them ever appears.
- Accept: transfer when in_valid & in_ready at an edge (edge T). in_ready = (inflight + fifo_count) < DEPTH, registered-free, with no dependence on in_valid. Without backpressure the block accepts one pair per cycle.
- Pipeline:
  - Edge T: x2 drives finv; s/e/m of x1 and sign/exp-zero flag of x2 are registered; valid bit v1 is set.
  - Cycle T+1: finv reciprocal r is valid. At edge T+1: 24×24 mantissa product {1,m1}×{1,mr} (48 bits), exponent sum e1+er, sign s1^s2 and special flags are registered (v2).
  - Edge T+2: normalize, pack, write the result into the FIFO.
  - out_valid rises in cycle T+3 when the FIFO was empty, giving 3-cycle accept-to-out_valid latency.
- Arithmetic:
  - If product bit 47 = 1: mantissa = p[46:24], exp = e1+er-126. Otherwise: mantissa = p[45:23], exp = e1+er-127.
  - Rounding: truncation. Exponent is computed at 10 bits signed.
  - Special cases, in priority order:
    1. x2 exponent = 0 → {s, 8'hFF, 23'h0} (signed infinity).
    2. x1 exponent = 0 → {s, 31'h0}.
    3. exp ≤ 0 → {s, 31'h0}.
    4. exp ≥ 255 → {s, 8'hFF, 23'h0}.
  - Inputs with exponent 255 are not checked; the result follows the arithmetic path.
- FIFO: DEPTH entries, circular, read/write pointers wrap modulo DEPTH.
  - y = head entry; y and out_valid are stable while out_valid & ~out_ready.
  - Pop when out_valid & out_ready.
  - A write and a pop in the same cycle are both performed; the count is unchanged.
- Credits: inflight increments on accept and decrements on FIFO write; simultaneous events net out. Because of the credit check, the FIFO never overflows, so the pipeline never stalls.
- Ordering: results are strictly in acceptance order.

Test Plan:
- Reset, then single op: x1=0x40C00000, x2=0x40000000 accepted at edge T → out_valid=1 in cycle T+3, y=0x40400000 (3.0). Also check y=0 and out_valid=0 during reset.
- Back-to-back: 0x3F800000/0x40800000 → 0x3E800000, then 0xC0400000/0x3F000000 → 0xC0C00000, with out_ready=1 → outputs on consecutive cycles, in order.
- Specials:
  - x2=0x00000000, x1=0xBF800000 → 0xFF800000.
  - x1=0x00000000, x2=0x40000000 → 0x00000000.
  - x1=0x00800000, x2=0x7F000000 → 0x00000000 (underflow).
- Backpressure: out_ready=0, in_valid=1 held with 6 distinct pairs → exactly 4 accepted, then in_ready=0; releasing out_ready drains 4 in order and in_ready rises again as credits free. No loss and no duplicates.
- Simultaneous push/pop at full credit: out_ready toggling every cycle with a continuous input stream → the count never exceeds DEPTH and the result sequence matches a reference model.
- Reset mid-operation: assert rst for 1 cycle with 3 ops in flight → no outputs from them; the next op after reset returns the correct value with 3-cycle latency.
